// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory-access sequencer.
// Holds the access-kind encodings, the sequencer state enum and helpers that
// classify an access kind as store and/or indirect.
package lc3_mem_pkg;

    localparam int unsigned LC3_ADDR_W = 16;
    localparam int unsigned LC3_DATA_W = 16;
    localparam int unsigned LC3_OP_W   = 2;

    typedef enum logic [LC3_OP_W-1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_LDI = 2'b10,
        OP_STI = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_GAP,
        ST_DONE
    } state_e;

    // True for accesses whose final memory cycle is a write.
    function automatic logic is_store(input logic [LC3_OP_W-1:0] op);
        return (op == OP_ST) || (op == OP_STI);
    endfunction

    // True for accesses that first fetch a pointer from memory.
    function automatic logic is_indirect(input logic [LC3_OP_W-1:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the last allowed one.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear of the count (has priority over en)
//   en          - count this cycle as a wait cycle
//   timeout_c   - combinational: this enabled cycle is wait cycle number LIMIT
// LIMIT = 0 disables the timeout entirely.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout_c
);

    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    // count holds the number of wait cycles already elapsed, so the
    // LIMIT-th wait cycle is the one that sees count == LIMIT-1.
    localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Wait-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= CNT_W'(count + 1'b1);
        end
    end

    assign timeout_c = (LIMIT != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory-access sequencer: latches the effective address into MAR, runs
// the request/ready handshake for LD, ST, LDI and STI, and reports a single
// done pulse (qualified by err on timeout) back to the datapath.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   start, op               - request pulse and access kind (sampled in IDLE)
//   eab_addr, st_data       - effective address and store data
//   busy, done, err         - status: busy outside IDLE, done pulse, timeout flag
//   ld_data, mar            - MDR and MAR contents
//   mem_en, mem_we          - memory request and write enable
//   mem_addr, mem_wdata     - memory address (MAR) and write data (MDR)
//   mem_rdata, mem_ready    - memory read data and completion strobe
module mem_access_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] eab_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] mar,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            state;
    logic [1:0]        op_q;
    logic              phase_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic              tmr_en_c;
    logic              tmr_clr_c;
    logic              timeout_c;

    // Only unanswered request cycles count toward the timeout.
    assign tmr_en_c  = (state == ST_ACCESS) && !mem_ready;
    assign tmr_clr_c = !tmr_en_c;

    mem_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tmr_clr_c),
        .en        (tmr_en_c),
        .timeout_c (timeout_c)
    );

    // Sequencer; mem_en/mem_we are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_LD;
            phase_q <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mar_q   <= eab_addr;
                        op_q    <= op;
                        phase_q <= is_indirect(op);
                        if (is_store(op)) begin
                            mdr_q <= st_data;
                        end
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        // Pointer fetch of STI is a read.
                        mem_we <= is_store(op) && !is_indirect(op);
                        state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (phase_q) begin
                            mar_q   <= ADDR_W'(mem_rdata);
                            phase_q <= 1'b0;
                            state   <= ST_GAP;
                        end else begin
                            if (!is_store(op_q)) begin
                                mdr_q <= mem_rdata;
                            end
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else if (timeout_c) begin
                        err    <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    mem_en <= 1'b1;
                    mem_we <= is_store(op_q);
                    state  <= ST_ACCESS;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mar       = mar_q;
    assign mem_addr  = mar_q;
    assign ld_data   = mdr_q;
    assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a transaction-level model expands each accepted
// access into the per-cycle outputs it must produce; a memory responder with
// scripted wait counts answers the bus; one process compares every cycle.
module tb_mem_access_ctrl;
    import lc3_mem_pkg::*;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] eab_addr;
    logic [15:0] st_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] ld_data;
    logic [15:0] mar;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    mem_access_ctrl #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .eab_addr  (eab_addr),
        .st_data   (st_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ld_data   (ld_data),
        .mar       (mar),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        done;
        logic        err;
        logic        en;
        logic        we;
        logic [15:0] mar;
        logic [15:0] mdr;
    } exp_t;

    exp_t        trace[$];
    int          wait_q[$];
    logic [15:0] bus_mem [0:65535];
    logic [15:0] mm      [0:65535];
    logic        m_err = 1'b0;
    logic [15:0] m_mar = 16'h0000;
    logic [15:0] m_mdr = 16'h0000;
    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    int          last_len = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [15:0] d);
        bus_mem[a] = d;
        mm[a]      = d;
    endtask

    // One memory access of w wait cycles: min(w+1, T) request cycles.
    task automatic acc(input logic [15:0] a, input logic we, input int w, output logic to);
        int n;
        n = (w >= int'(T)) ? int'(T) : w + 1;
        for (int i = 0; i < n; i++) begin
            trace.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b1, we, a, m_mdr});
        end
        to = (w >= int'(T));
    endtask

    // Build the expected trace of one access sequence, then pulse start.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] s,
                         input int w0, input int w1);
        logic to;
        m_err = 1'b0;
        m_mar = a;
        if (is_store(o)) m_mdr = s;
        wait_q.push_back(w0);
        if (is_indirect(o)) begin
            acc(a, 1'b0, w0, to);
            if (!to) begin
                m_mar = mm[a];
                trace.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_mar, m_mdr});
                wait_q.push_back(w1);
                acc(m_mar, is_store(o), w1, to);
            end
        end else begin
            acc(a, is_store(o), w0, to);
        end
        if (to) m_err = 1'b1;
        else if (is_store(o)) mm[m_mar] = m_mdr;
        else m_mdr = mm[m_mar];
        trace.push_back(exp_t'{1'b1, 1'b1, m_err, 1'b0, 1'b0, m_mar, m_mdr});
        last_len = trace.size();
        start = 1'b1; op = o; eab_addr = a; st_data = s;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); eab_addr = 16'($urandom); st_data = 16'($urandom);
    endtask

    // Run out the sequence, optionally firing ignored start pulses while busy
    // and in the DONE cycle; returns at the first IDLE cycle.
    task automatic finish_op(input bit noise);
        while (trace.size() > 0) begin
            start = noise && ($urandom_range(0, 2) == 0);
            op = 2'($urandom); eab_addr = 16'($urandom); st_data = 16'($urandom);
            @(negedge clk);
        end
        start = noise;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Memory responder: answers each request after its scripted wait count.
    bit req_act = 1'b0;
    int wcnt = 0;
    int need = 0;
    always @(negedge clk) begin
        if (mem_en !== 1'b1) begin
            req_act   = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
        end else begin
            if (!req_act) begin
                req_act = 1'b1;
                wcnt    = 0;
                need    = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            if (wcnt == need) begin
                mem_ready = 1'b1;
                mem_rdata = bus_mem[mem_addr];
                if (mem_we) bus_mem[mem_addr] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
                wcnt++;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                exp_t e;
                if (trace.size() > 0) e = trace.pop_front();
                else e = exp_t'{1'b0, 1'b0, m_err, 1'b0, 1'b0, m_mar, m_mdr};
                chk("busy",      16'(busy),   16'(e.busy));
                chk("done",      16'(done),   16'(e.done));
                chk("err",       16'(err),    16'(e.err));
                chk("mem_en",    16'(mem_en), 16'(e.en));
                chk("mem_we",    16'(mem_we), 16'(e.we));
                chk("mar",       mar,         e.mar);
                chk("mem_addr",  mem_addr,    e.mar);
                chk("ld_data",   ld_data,     e.mdr);
                chk("mem_wdata", mem_wdata,   e.mdr);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; eab_addr = 16'h0000; st_data = 16'h0000;
        mem_ready = 1'b0; mem_rdata = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 16'($urandom);
            mm[i]      = bus_mem[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_busy",   16'(busy),   16'h0);
        chk("rst_done",   16'(done),   16'h0);
        chk("rst_err",    16'(err),    16'h0);
        chk("rst_mem_en", 16'(mem_en), 16'h0);
        chk("rst_mar",    mar,         16'h0000);
        chk("rst_mdr",    ld_data,     16'h0000);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // LD, zero wait
        set_mem(16'h3050, 16'h1234);
        issue(OP_LD, 16'h3050, 16'h0000, 0, 0);
        chk("ld_len", 16'(last_len), 16'd2);
        finish_op(1'b0);
        chk("ld_data_lit", ld_data, 16'h1234);

        // ST, three wait cycles
        issue(OP_ST, 16'h4000, 16'hBEEF, 3, 0);
        chk("st_len", 16'(last_len), 16'd5);
        finish_op(1'b0);
        chk("st_mem", bus_mem[16'h4000], 16'hBEEF);

        // LDI
        set_mem(16'h3100, 16'h5000);
        set_mem(16'h5000, 16'hCAFE);
        issue(OP_LDI, 16'h3100, 16'h0000, 0, 0);
        chk("ldi_len", 16'(last_len), 16'd4);
        finish_op(1'b0);
        chk("ldi_data_lit", ld_data, 16'hCAFE);

        // STI
        set_mem(16'h3200, 16'h6001);
        issue(OP_STI, 16'h3200, 16'h00AA, 0, 0);
        chk("sti_len", 16'(last_len), 16'd4);
        finish_op(1'b0);
        chk("sti_mem", bus_mem[16'h6001], 16'h00AA);

        // Timeout with start pulses while busy
        issue(OP_LD, 16'h7777, 16'h0000, 100, 0);
        chk("to_len", 16'(last_len), 16'd5);
        finish_op(1'b1);
        chk("to_err_lit", 16'(err), 16'h1);
        chk("to_mdr_lit", ld_data,  16'h00AA);

        // Pointer extremes
        set_mem(16'h0010, 16'hFFFF);
        set_mem(16'hFFFF, 16'h1357);
        issue(OP_LDI, 16'h0010, 16'h0000, 1, 2);
        finish_op(1'b1);
        chk("ptr_ffff_lit", ld_data, 16'h1357);
        set_mem(16'h0020, 16'h0000);
        issue(OP_STI, 16'h0020, 16'h2468, 2, 1);
        finish_op(1'b1);
        chk("ptr_0000_mem", bus_mem[16'h0000], 16'h2468);

        // Reset in the middle of an LDI pointer fetch
        set_mem(16'h3300, 16'h7000);
        issue(OP_LDI, 16'h3300, 16'h0000, 3, 0);
        @(negedge clk);
        rst_n = 1'b0;
        trace.delete(); wait_q.delete();
        m_err = 1'b0; m_mar = 16'h0000; m_mdr = 16'h0000;
        #1;
        chk("arst_mem_en", 16'(mem_en), 16'h0);
        chk("arst_mem_we", 16'(mem_we), 16'h0);
        chk("arst_busy",   16'(busy),   16'h0);
        chk("arst_mar",    mar,         16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_mem(16'h3051, 16'h4321);
        issue(OP_LD, 16'h3051, 16'h0000, 1, 0);
        finish_op(1'b0);
        chk("post_rst_ld", ld_data, 16'h4321);

        // Randomized sequences
        for (int n = 0; n < 250; n++) begin
            issue(2'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 5), $urandom_range(0, 5));
            finish_op(1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access sequencer that sits directly downstream of the effective-address adder.
- Latches the computed effective address into MAR and runs the LC-3 memory handshake (request held until the R/ready signal).
- Performs LD/ST and the two-access indirect forms LDI/STI, returning load data through MDR.
- Gives the datapath one clean start/done interface, regardless of how many cycles memory takes.

Parameters:
ADDR_W, 16, address width (MAR, eab_addr, mem_addr)
DATA_W, 16, data width (MDR, store/load data, memory bus)
TIMEOUT_CYCLES, 64, max cycles waiting for mem_ready per access; 0 disables timeout

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse; sampled only in IDLE
op  input  2  access kind: 00 LD, 01 ST, 10 LDI, 11 STI
eab_addr  input  16  effective address from the address adder
st_data  input  16  store data (source register), sampled with start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when access sequence completes
err  output  1  qualifies done: sequence aborted by timeout
ld_data  output  16  MDR contents; valid for loads when done=1, held until next start
mar  output  16  current MAR value (debug/trace)
mem_en  output  1  memory request
mem_we  output  1  write enable, only asserted with mem_en
mem_addr  output  16  equals MAR
mem_wdata  output  16  equals MDR
mem_rdata  input  16  read data, valid when mem_ready=1
mem_ready  input  1  memory R signal: current request completes this cycle

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-low (rst_n), applied immediately and released synchronously.
  - Reset values: state=IDLE, MAR=0, MDR=0, busy=0, done=0, err=0, mem_en=0, mem_we=0, timer=0.
- States: IDLE, ACCESS, GAP, DONE. The register phase_q is 1 while an indirect pointer fetch is in progress.
- IDLE:
  - On start=1: MAR<=eab_addr, op_q<=op. For ST/STI, MDR<=st_data (otherwise MDR unchanged).
  - Also on start: phase_q<=1 for LDI/STI and 0 otherwise; then go to ACCESS.
- ACCESS:
  - mem_en=1, mem_addr=MAR, mem_wdata=MDR.
  - mem_we=1 only when phase_q=0 and op_q is ST or STI.
  - Stay while mem_ready=0; the timer increments every such cycle.
- On mem_ready=1 in ACCESS (timer cleared):
  - If phase_q=1: MAR<=mem_rdata, phase_q<=0, go to GAP.
  - Else if load (LD/LDI): MDR<=mem_rdata, go to DONE.
  - Else (store): go to DONE.
- GAP: mem_en=0 for exactly one cycle; every request is separated by at least one idle bus cycle. Then go to ACCESS.
- Timeout:
  - With TIMEOUT_CYCLES>0, when the timer reaches TIMEOUT_CYCLES in ACCESS with mem_ready=0: set err<=1, drop the request, go to DONE.
  - MDR is unchanged on timeout.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - err is cleared on the next accepted start.
- Latency (mem_ready high on the first request cycle):
  - LD/ST: start at cycle 0, request at cycle 1, done at cycle 2.
  - LDI/STI: requests at cycles 1 and 3, done at cycle 4.
  - Each wait cycle adds 1.
- Boundary conditions:
  - start while busy=1 is ignored, and no state is captured.
  - start in the DONE cycle is also ignored; it is accepted the following cycle.
  - An op change during busy has no effect, because op_q is used.
  - Addresses are used verbatim. An indirect pointer of 0x0000 or 0xFFFF is legal, with no wrap handling needed.
  - mem_ready while mem_en=0 is ignored.
  - When rst_n falls mid-access, mem_en/mem_we drop in the same cycle (asynchronously), and no done is produced.

Decomposition:
- Shared package lc3_mem_pkg holds:
  - op encodings (OP_LD, OP_ST, OP_LDI, OP_STI)
  - state enum (ST_IDLE, ST_ACCESS, ST_GAP, ST_DONE)
  - the is_store/is_indirect helper functions
- One sub-module, mem_wait_timer: a cycle counter with clear, enable and a parameterised limit, producing a timeout pulse.

Test Plan:
- LD, zero wait: op=00, eab_addr=0x3050, memory returns 0x1234 with mem_ready on the first request cycle. Required: mem_addr=0x3050 at cycle 1, done at cycle 2, ld_data=0x1234, err=0.
- ST, 3 wait cycles: op=01, eab_addr=0x4000, st_data=0xBEEF. Required: mem_en=mem_we=1 with mem_wdata=0xBEEF held for 4 cycles, done at cycle 5, memory[0x4000]=0xBEEF.
- LDI: mem[0x3100]=0x5000, mem[0x5000]=0xCAFE. Required: first read at 0x3100 with we=0; a GAP cycle with mem_en=0; second read at 0x5000; ld_data=0xCAFE; done at cycle 4.
- STI: mem[0x3200]=0x6001, st_data=0x00AA. Required: first access is a read of 0x3200, second is a write of 0x00AA at 0x6001; mem_we is never high during the pointer fetch.
- Timeout and busy ignore:
  - With TIMEOUT_CYCLES=4 and mem_ready held low, issue LD. Required: done with err=1 after 4 wait cycles and MDR unchanged.
  - A second start pulse during busy is ignored.
- Reset mid-access: deassert rst_n during ACCESS of an LDI. Required: mem_en drops immediately, all outputs return to reset values, no done pulse, and a subsequent LD completes normally.
